ah_w2n_rr_scheduler: RTL and testbench
======================================

# ah_w2n_rr_scheduler

Round-robin scheduler that shares one wide-to-narrow packet serializer between several wide-word requesters. It grants one requester at a time, captures its IN_W-bit word and emits it as IN_W/OUT_W narrow beats on a single ready/valid output. Packets are never interleaved. It sits in front of the narrow link in the packet-converter path, replacing one converter per source.

## Interface
- NUM_REQ, 4, number of requesters (≥1)
- IN_W, 32, requester word width; integer multiple of OUT_W
- OUT_W, 8, output beat width; BEATS = IN_W/OUT_W (≥1)
- clk  input  1  clock, all state on rising edge
- rstn  input  1  reset, asynchronous, active-low
- req_data  input  NUM_REQ*IN_W  requester words; requester i occupies bits [i*IN_W +: IN_W]
- req_valid  input  NUM_REQ  per-requester valid
- req_ready  output  NUM_REQ  per-requester accept, one-hot or zero
- out_data  output  OUT_W  current beat
- out_valid  output  1  beat valid
- out_ready  input  1  downstream accept
- out_last  output  1  final beat of the packet
- out_src  output  max(1,$clog2(NUM_REQ))  index of the requester owning the current packet
- busy  output  1  a packet is loaded (equals out_valid)

## Operation
- States: IDLE, SEND. Registers: shift/word register (IN_W), beat counter (0..BEATS-1), RR pointer ptr, out_src.
- Load condition: state==IDLE, or state==SEND with out_valid && out_ready && out_last.
- Arbitration on load: scan requesters ptr, ptr+1, … mod NUM_REQ. The first with req_valid high is granted (g).
- On grant: req_ready[g]=1 for that cycle only. Capture req_data[g], set out_src=g, beat counter=0, ptr=(g+1) mod NUM_REQ, state=SEND.
- On load with no valid requester: state=IDLE, out_valid=0.
- req_ready is combinational from state, req_valid, ptr and out_ready. No requester sees ready outside a load cycle.
- In SEND: out_data = slice of the captured word selected by the beat counter. Order is LSB-first by default.
- Non-final beat handshake (out_valid && out_ready): beat counter +1.
- out_last = (beat counter == BEATS-1) && out_valid.
- BEATS==1: every packet is a single beat with out_last=1.
- Backpressure: while out_ready=0, out_data, out_last and out_src are held stable and out_valid stays 1.
- A requester dropping req_valid without a handshake is a protocol violation and has no defined effect beyond losing that cycle's grant.
- NUM_REQ==1: ptr is constant 0; out_src is 1 bit, tied 0.

## Timing
- Reset (asynchronous, immediate): out_valid=0, out_last=0, out_data=0, out_src=0, busy=0, req_ready=0, ptr=0, state=IDLE, beat counter=0.
- A partial packet at reset is discarded and not re-requested.
- Latency: a requester granted in cycle N produces its first beat with out_valid=1 in cycle N+1.
- Packet duration: BEATS cycles with out_ready held high.
- Back-to-back: the next grant happens in the same cycle as the last-beat handshake, so there is zero bubble between packets.
- Sustained throughput: one beat per cycle.
- Fairness: with all requesters continuously valid, each is served exactly once per NUM_REQ packets.

## Configuration
- AH_W2N_SCHED_MSB_FIRST_EN defined: beats are emitted most-significant slice first, i.e. beat k = word[IN_W-1-k*OUT_W -: OUT_W].
- AH_W2N_SCHED_MSB_FIRST_EN undefined (default): LSB-first, i.e. beat k = word[k*OUT_W +: OUT_W].
- The macro affects only beat order. Timing and arbitration are identical either way.

## Test plan
- Single packet (defaults, out_ready=1): req 1 presents 0xA1B2C3D4 from IDLE.
  - req_ready=4'b0010 for one cycle.
  - Beats D4, C3, B2, A1 on the next 4 cycles, out_src=1, out_last only on A1.
- All four requesters continuously valid, out_ready=1:
  - Grant order 0, 1, 2, 3, 0.
  - out_valid stays high for 20 consecutive cycles and out_last pulses every 4th cycle.
- Backpressure: out_ready=0 for 3 cycles while beat B2 is presented.
  - out_data holds 0xB2 with out_valid=1.
  - No beat is duplicated or dropped; A1 follows after ready returns.
- Back-to-back handover: req 2 valid while req 0's last beat handshakes.
  - req_ready[2]=1 in that same cycle.
  - First beat of req 2 appears the next cycle with out_src=2.
- Reset mid-packet: assert rstn=0 after beat 1.
  - Outputs go to zero immediately.
  - After release, an idle-valid req 3 and req 0 are granted in order 0 then 3 (ptr=0).
- With AH_W2N_SCHED_MSB_FIRST_EN: word 0xA1B2C3D4 yields beats A1, B2, C3, D4, with out_last on D4.

Source files
------------

// File: rtl/ah_w2n_rr_scheduler.sv
// Round-robin scheduler that shares one wide-to-narrow serializer between NUM_REQ requesters.
// Optional macro AH_W2N_SCHED_MSB_FIRST_EN emits beats most-significant slice first.
module ah_w2n_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int IN_W    = 32,
  parameter int OUT_W   = 8,
  localparam int BEATS  = IN_W / OUT_W,
  localparam int SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NUM_REQ*IN_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [OUT_W-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic [SRC_W-1:0]        out_src,
  output logic                    busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [IN_W-1:0]     word_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [SRC_W-1:0]    ptr_r;
  logic [SRC_W-1:0]    src_r;

  logic [IN_W-1:0]     words_s [NUM_REQ];
  logic [SRC_W-1:0]    scan_idx_s [NUM_REQ];
  logic [SRC_W-1:0]    grant_s;
  logic [SRC_W-1:0]    ptr_nxt_s;
  logic                found_s;
  logic                last_s;
  logic                load_s;
  logic                grant_ok_s;
  logic                beat_s;
  logic [IN_W-1:0]     shifted_s;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
    assign words_s[i] = req_data[i*IN_W +: IN_W];
  end

  assign last_s     = (state_r == SEND) && (cnt_r == CNT_W'(BEATS - 1));
  // rstn gates the load so no requester sees ready while reset is held
  assign load_s     = rstn && ((state_r == IDLE) || (out_ready && last_s));
  assign found_s    = |req_valid;
  assign grant_ok_s = load_s && found_s;
  assign beat_s     = (state_r == SEND) && out_ready && !last_s;

`ifdef AH_W2N_SCHED_MSB_FIRST_EN
  assign shifted_s = word_r << OUT_W;
  assign out_data  = word_r[IN_W-1 -: OUT_W];
`else
  assign shifted_s = word_r >> OUT_W;
  assign out_data  = word_r[OUT_W-1:0];
`endif

  assign out_valid = (state_r == SEND);
  assign busy      = (state_r == SEND);
  assign out_last  = last_s;
  assign out_src   = src_r;

  // Round-robin scan from ptr; descending pass so the nearest valid requester wins
  always_comb begin
    grant_s = {SRC_W{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx_s[k] = SRC_W'((int'(ptr_r) + k) % NUM_REQ);
    end
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      grant_s = req_valid[scan_idx_s[k]] ? scan_idx_s[k] : grant_s;
    end
    ptr_nxt_s = SRC_W'((int'(grant_s) + 1) % NUM_REQ);
  end

  // One-hot accept pulse for the granted requester during a load cycle
  always_comb begin
    req_ready = {NUM_REQ{1'b0}};
    if (grant_ok_s) begin
      req_ready[grant_s] = 1'b1;
    end else begin
      req_ready = {NUM_REQ{1'b0}};
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_nxt_s = SEND;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SEND: begin
        if (out_ready && last_s) begin
          state_nxt_s = found_s ? SEND : IDLE;
        end else begin
          state_nxt_s = SEND;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Word capture, beat shifting and round-robin pointer update
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      word_r <= {IN_W{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
      ptr_r  <= {SRC_W{1'b0}};
      src_r  <= {SRC_W{1'b0}};
    end else if (grant_ok_s) begin
      word_r <= words_s[grant_s];
      cnt_r  <= {CNT_W{1'b0}};
      ptr_r  <= ptr_nxt_s;
      src_r  <= grant_s;
    end else if (load_s) begin
      word_r <= {IN_W{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
    end else if (beat_s) begin
      word_r <= shifted_s;
      cnt_r  <= cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ah_w2n_rr_scheduler.sv
// Self-checking bench for ah_w2n_rr_scheduler: table-driven single packets plus
// hand-written sequences; expected beats flow through a scoreboard queue.
module tb_ah_w2n_rr_scheduler;

  logic         clk = 1'b0;
  logic         rstn;
  logic [127:0] req_data;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic [1:0]   out_src;
  logic         busy;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic [1:0] src;
  } beat_t;

  typedef struct {
    int          idx;
    logic [31:0] word;
    logic [3:0]  exp_ready;
  } vec_t;

  beat_t sb[$];
  vec_t  tbl[4];

  ah_w2n_rr_scheduler #(.NUM_REQ(4), .IN_W(32), .OUT_W(8)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_data  (req_data),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_src   (out_src),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_beat(input logic [31:0] w, input int k);
    logic [31:0] t;
`ifdef AH_W2N_SCHED_MSB_FIRST_EN
    t = w >> (24 - 8 * k);
`else
    t = w >> (8 * k);
`endif
    return t[7:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_pkt(input int src, input logic [31:0] w);
    beat_t b;
    for (int k = 0; k < 4; k++) begin
      b.data = exp_beat(w, k);
      b.last = (k == 3);
      b.src  = 2'(src);
      sb.push_back(b);
    end
  endtask

  // One cycle: drive at negedge, check combinational grant and any handshaked beat
  task automatic step(input logic [3:0] v, input logic rdy, input logic [3:0] exp_rr);
    beat_t e;
    @(negedge clk);
    req_valid = v;
    out_ready = rdy;
    #1;
    chk("req_ready", {28'd0, req_ready}, {28'd0, exp_rr});
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL extra_beat: got data %h src %0d, expected no beat", out_data, out_src);
      end else begin
        e = sb.pop_front();
        chk("beat", {21'd0, out_data, out_last, out_src}, {21'd0, e.data, e.last, e.src});
      end
    end
  endtask

  task automatic chk_idle(input string nm);
    chk(nm, {30'd0, out_valid, busy}, 32'd0);
    chk({nm, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rstn      = 1'b0;
    req_valid = 4'b0000;
    out_ready = 1'b1;
    req_data  = 128'd0;
    #1;
    chk("rst_outputs", {17'd0, out_valid, out_last, out_data, out_src, busy, req_ready},
        32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Single packets from IDLE, one requester each
    tbl[0] = '{idx: 1, word: 32'hA1B2C3D4, exp_ready: 4'b0010};
    tbl[1] = '{idx: 0, word: 32'h11223344, exp_ready: 4'b0001};
    tbl[2] = '{idx: 3, word: 32'hDEADBEEF, exp_ready: 4'b1000};
    tbl[3] = '{idx: 2, word: 32'h00FF00FF, exp_ready: 4'b0100};
    for (int i = 0; i < 4; i++) begin
      req_data[tbl[i].idx*32 +: 32] = tbl[i].word;
      step(tbl[i].exp_ready, 1'b1, tbl[i].exp_ready);
      push_pkt(tbl[i].idx, tbl[i].word);
      for (int b = 0; b < 4; b++) step(4'b0000, 1'b1, 4'b0000);
      step(4'b0000, 1'b1, 4'b0000);
      chk_idle("single_idle");
    end

    // All requesters valid after reset: fair rotation with no bubbles
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int r = 0; r < 4; r++) req_data[r*32 +: 32] = 32'h10203040 + 32'(r) * 32'h01010101;
    for (int c = 0; c <= 24; c++) begin
      logic [3:0] er;
      er = 4'b0000;
      if ((c % 4 == 0) && (c <= 20)) er[(c / 4) % 4] = 1'b1;
      step((c <= 20) ? 4'b1111 : 4'b0000, 1'b1, er);
      if (er != 4'b0000) push_pkt((c / 4) % 4, req_data[((c / 4) % 4)*32 +: 32]);
      if (c >= 1) chk("rr_stream", {30'd0, out_valid, out_last}, {30'd0, 1'b1, (c % 4 == 0)});
    end
    step(4'b0000, 1'b1, 4'b0000);
    chk_idle("rr_idle");

    // Backpressure on the third beat
    req_data[1*32 +: 32] = 32'hA1B2C3D4;
    step(4'b0010, 1'b1, 4'b0010);
    push_pkt(1, 32'hA1B2C3D4);
    step(4'b0000, 1'b1, 4'b0000);
    step(4'b0000, 1'b1, 4'b0000);
    for (int s = 0; s < 3; s++) begin
      step(4'b0000, 1'b0, 4'b0000);
      chk("bp_hold", {23'd0, out_valid, out_data}, {23'd0, 1'b1, exp_beat(32'hA1B2C3D4, 2)});
    end
    step(4'b0000, 1'b1, 4'b0000);
    step(4'b0000, 1'b1, 4'b0000);
    step(4'b0000, 1'b1, 4'b0000);
    chk_idle("bp_idle");

    // Back-to-back handover from req 0 to req 2
    req_data[0*32 +: 32] = 32'h55667788;
    req_data[2*32 +: 32] = 32'h0BADF00D;
    step(4'b0001, 1'b1, 4'b0001);
    push_pkt(0, 32'h55667788);
    for (int b = 0; b < 3; b++) step(4'b0000, 1'b1, 4'b0000);
    step(4'b0100, 1'b1, 4'b0100);
    push_pkt(2, 32'h0BADF00D);
    step(4'b0000, 1'b1, 4'b0000);
    chk("b2b_first", {29'd0, out_valid, out_src}, {29'd0, 1'b1, 2'd2});
    for (int b = 0; b < 3; b++) step(4'b0000, 1'b1, 4'b0000);
    step(4'b0000, 1'b1, 4'b0000);
    chk_idle("b2b_idle");

    // Reset in the middle of a packet, then pointer restarts at 0
    req_data[1*32 +: 32] = 32'hCAFEF00D;
    step(4'b0010, 1'b1, 4'b0010);
    push_pkt(1, 32'hCAFEF00D);
    step(4'b0000, 1'b1, 4'b0000);
    step(4'b0000, 1'b1, 4'b0000);
    @(negedge clk);
    req_valid = 4'b1001;
    rstn      = 1'b0;
    #1;
    chk("midrst_outputs", {17'd0, out_valid, out_last, out_data, out_src, busy, req_ready},
        32'd0);
    sb.delete();
    @(negedge clk);
    req_valid = 4'b0000;
    rstn      = 1'b1;
    req_data[0*32 +: 32] = 32'h01234567;
    req_data[3*32 +: 32] = 32'h89ABCDEF;
    step(4'b1001, 1'b1, 4'b0001);
    push_pkt(0, 32'h01234567);
    for (int b = 0; b < 3; b++) step(4'b1000, 1'b1, 4'b0000);
    step(4'b1000, 1'b1, 4'b1000);
    push_pkt(3, 32'h89ABCDEF);
    for (int b = 0; b < 4; b++) step(4'b0000, 1'b1, 4'b0000);
    step(4'b0000, 1'b1, 4'b0000);
    chk_idle("midrst_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
